// File: rtl/mips_pkg.sv
// mips_pkg: R-type opcode/funct constants, execute FSM states and ALU op decode.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef enum logic [1:0] {IDLE, DEC, EX, WB} state_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU, ALU_ILL
    } alu_op_t;

    // Trapping and wrapping variants share one datapath op; trap gating lives in the sequencer.
    function automatic alu_op_t decode_funct(input logic [5:0] f);
        alu_op_t op;
        case (f)
            FUNCT_SLL, FUNCT_SLLV: op = ALU_SLL;
            FUNCT_SRL, FUNCT_SRLV: op = ALU_SRL;
            FUNCT_SRA, FUNCT_SRAV: op = ALU_SRA;
            FUNCT_ADD, FUNCT_ADDU: op = ALU_ADD;
            FUNCT_SUB, FUNCT_SUBU: op = ALU_SUB;
            FUNCT_AND:             op = ALU_AND;
            FUNCT_OR:              op = ALU_OR;
            FUNCT_XOR:             op = ALU_XOR;
            FUNCT_NOR:             op = ALU_NOR;
            FUNCT_SLT:             op = ALU_SLT;
            FUNCT_SLTU:            op = ALU_SLTU;
            default:               op = ALU_ILL;
        endcase
        return op;
    endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational R-type ALU with signed-overflow flag and funct legality.
module alu_core
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              legal
);
    alu_op_t           op;
    logic [4:0]        sh;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign op    = decode_funct(funct);
    // funct[2] separates the variable shifts (amount from rs) from the immediate ones
    assign sh    = funct[2] ? a[4:0] : shamt;
    assign sum   = a + b;
    assign diff  = a - b;
    assign legal = op != ALU_ILL;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_SLL:  result = b << sh;
            ALU_SRL:  result = b >> sh;
            ALU_SRA:  result = $unsigned($signed(b) >>> sh);
            ALU_ADD: begin
                result   = sum;
                overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, a < b};
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/rtype_exec_ctrl.sv
// rtype_exec_ctrl: multi-cycle R-type sequencer driving a registered-read 2R/1W register file.
// DEC issues reads, EX captures the ALU result, WB drives the write port for one cycle.
module rtype_exec_ctrl
    import mips_pkg::*;
#(
    parameter bit OVF_TRAP = 1'b1,
    parameter int DATA_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              inst_valid,
    input  logic [31:0]       inst,
    output logic              inst_ready,
    output logic [4:0]        R_Addr_A,
    output logic [4:0]        R_Addr_B,
    input  logic [DATA_W-1:0] R_Data_A,
    input  logic [DATA_W-1:0] R_Data_B,
    output logic [4:0]        W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              WE,
    output logic              done,
    output logic              ovf,
    output logic              illegal,
    output logic              zero
);
    state_t            state, state_n;
    logic [31:0]       ir;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] alu_res;
    logic              ovf_q;
    logic              illegal_q;
    logic              alu_ovf;
    logic              alu_legal;
    logic              accept;
    logic              dec_ok;

    assign R_Addr_A = ir[25:21];
    assign R_Addr_B = ir[20:16];
    assign accept   = inst_valid && inst_ready;
    assign dec_ok   = (ir[31:26] == OP_RTYPE) && alu_legal;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .funct    (ir[5:0]),
        .a        (R_Data_A),
        .b        (R_Data_B),
        .shamt    (ir[10:6]),
        .result   (alu_res),
        .overflow (alu_ovf),
        .legal    (alu_legal)
    );

    // Outputs decode straight from state so the async reset drops WE without waiting for a clock.
    always_comb begin
        inst_ready = (state == IDLE) || (state == WB);
        done       = state == WB;
        WE         = done && !ovf_q;
        ovf        = done && ovf_q;
        zero       = done && (res == '0);
        W_Addr     = done ? rd_q : '0;
        W_Data     = done ? res : '0;
        illegal    = illegal_q;
        state_n    = inst_ready ? (accept ? DEC : IDLE)
                   : state == DEC ? (dec_ok ? EX : IDLE)
                   : WB;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            ir        <= '0;
            rd_q      <= '0;
            res       <= '0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_n;
            illegal_q <= (state == DEC) && !dec_ok;
            if (accept)
                ir <= inst;
            // rd/result live apart from ir so an instruction accepted in WB cannot disturb the write
            if (state == EX) begin
                res   <= alu_res;
                rd_q  <= ir[15:11];
                ovf_q <= OVF_TRAP && alu_ovf && (ir[5:0] == FUNCT_ADD || ir[5:0] == FUNCT_SUB);
            end
        end
    end
endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// tb_rtype_exec_ctrl: directed + randomized checks of rtype_exec_ctrl against a
// behavioural register file and an arithmetic reference model of the R-type ALU.
module tb_rtype_exec_ctrl;
    import mips_pkg::*;

    logic        CLK, RST, inst_valid, inst_ready, WE, done, ovf, illegal, zero;
    logic [31:0] inst, R_Data_A, R_Data_B, W_Data;
    logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
    logic [31:0] rf [32];
    int          checks, failures;
    longint      acc_t;

    rtype_exec_ctrl dut (
        .CLK(CLK), .RST(RST), .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
        .W_Addr(W_Addr), .W_Data(W_Data), .WE(WE), .done(done), .ovf(ovf),
        .illegal(illegal), .zero(zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // register file: registered reads sampled only when no write, r0 write-protected
    always @(posedge CLK) begin
        if (WE && W_Addr != 5'd0) rf[W_Addr] <= W_Data;
        if (!WE) begin
            R_Data_A <= rf[R_Addr_A];
            R_Data_B <= rf[R_Addr_B];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int rs, input int rt, input int rd, input int sh, input logic [5:0] f);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), f};
    endfunction

    function automatic bit legal_f(input logic [5:0] f);
        return f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B};
    endfunction

    // reference semantics in 64-bit integer arithmetic
    task automatic ref_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, output logic [31:0] r, output logic trap);
        longint sa, sb, s;
        int     n;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        n    = f[2] ? int'(a[4:0]) : int'(sh);
        trap = 1'b0;
        s    = 0;
        case (f)
            6'h00, 6'h04: r = 32'(longint'(b) * (longint'(1) << n));
            6'h02, 6'h06: r = 32'(longint'(b) / (longint'(1) << n));
            6'h03, 6'h07: r = 32'(sb >> n);
            6'h20: begin s = sa + sb; r = 32'(s); trap = s > 64'sd2147483647 || s < -64'sd2147483648; end
            6'h21: r = 32'(sa + sb);
            6'h22: begin s = sa - sb; r = 32'(s); trap = s > 64'sd2147483647 || s < -64'sd2147483648; end
            6'h23: r = 32'(sa - sb);
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
    endtask

    // pre: already accepted at the previous edge; chain: offer nxt during WB
    task automatic run(input logic [31:0] ins, input bit pre, input bit chain, input logic [31:0] nxt);
        logic [31:0] er, old;
        logic        et;
        bit          leg;
        int          n;
        if (!pre) begin
            n = 0;
            while (!inst_ready && n < 20) begin @(negedge CLK); n++; end
            chk("ready_wait", {31'd0, inst_ready}, 32'd1);
            inst_valid = 1'b1;
            inst = ins;
            @(posedge CLK);
            acc_t = longint'($time);
            #1 inst_valid = 1'b0;
        end
        leg = ins[31:26] == 6'h00 && legal_f(ins[5:0]);
        @(negedge CLK);
        chk("dec_ready", {31'd0, inst_ready}, 32'd0);
        chk("dec_we", {31'd0, WE}, 32'd0);
        chk("dec_raddr_a", {27'd0, R_Addr_A}, {27'd0, ins[25:21]});
        chk("dec_raddr_b", {27'd0, R_Addr_B}, {27'd0, ins[20:16]});
        ref_alu(ins[5:0], rf[ins[25:21]], rf[ins[20:16]], ins[10:6], er, et);
        old = rf[ins[15:11]];
        if (!leg) begin
            @(negedge CLK);
            chk("ill_pulse", {31'd0, illegal}, 32'd1);
            chk("ill_we", {31'd0, WE}, 32'd0);
            chk("ill_done", {31'd0, done}, 32'd0);
            chk("ill_ready", {31'd0, inst_ready}, 32'd1);
            @(negedge CLK);
            chk("ill_clear", {31'd0, illegal}, 32'd0);
            chk("ill_we2", {31'd0, WE}, 32'd0);
            chk("ill_rd_kept", rf[ins[15:11]], old);
            return;
        end
        @(negedge CLK);
        chk("ex_we", {31'd0, WE}, 32'd0);
        chk("ex_ready", {31'd0, inst_ready}, 32'd0);
        chk("ex_done", {31'd0, done}, 32'd0);
        @(negedge CLK);
        chk("wb_done", {31'd0, done}, 32'd1);
        chk("wb_we", {31'd0, WE}, {31'd0, !et});
        chk("wb_waddr", {27'd0, W_Addr}, {27'd0, ins[15:11]});
        chk("wb_wdata", W_Data, er);
        chk("wb_ovf", {31'd0, ovf}, {31'd0, et});
        chk("wb_zero", {31'd0, zero}, {31'd0, er == 32'd0});
        chk("wb_ready", {31'd0, inst_ready}, 32'd1);
        if (chain) begin
            inst_valid = 1'b1;
            inst = nxt;
        end
        @(posedge CLK);
        if (chain) begin
            chk("spacing", 32'(longint'($time) - acc_t), 32'd30);
            acc_t = longint'($time);
        end
        #1 inst_valid = 1'b0;
        chk("rf_after", rf[ins[15:11]], ins[15:11] == 5'd0 ? 32'd0 : (et ? old : er));
    endtask

    logic [5:0]  lf [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                             6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [31:0] ri;

    initial begin
        checks = 0;
        failures = 0;
        acc_t = 0;
        RST = 1'b1;
        inst_valid = 1'b0;
        inst = 32'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        repeat (2) @(negedge CLK);
        chk("rst_we", {31'd0, WE}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ill", {31'd0, illegal}, 32'd0);
        chk("rst_waddr", {27'd0, W_Addr}, 32'd0);
        chk("rst_wdata", W_Data, 32'd0);
        RST = 1'b0;
        #1 chk("rst_ready", {31'd0, inst_ready}, 32'd1);

        rf[1] = 32'd5; rf[2] = 32'd7;
        run(32'h00221821, 0, 0, 0);
        chk("t1_r3", rf[3], 32'd12);

        rf[1] = 32'h80000000; rf[2] = 32'd1; rf[4] = 32'd0;
        run(enc(1, 2, 4, 0, 6'h22), 0, 0, 0);
        chk("t2_sub_r4", rf[4], 32'd0);
        run(enc(1, 2, 4, 0, 6'h23), 0, 0, 0);
        chk("t2_subu_r4", rf[4], 32'h7FFFFFFF);

        rf[1] = 32'd5; rf[2] = 32'd7; rf[3] = 32'd0;
        run(enc(1, 2, 3, 0, 6'h21), 0, 1, enc(0, 3, 5, 4, 6'h00));
        run(enc(0, 3, 5, 4, 6'h00), 1, 0, 0);
        chk("t3_r5", rf[5], 32'h000000C0);

        rf[1] = 32'hFFFFFFFF; rf[2] = 32'd1;
        run(enc(1, 2, 6, 0, 6'h2A), 0, 0, 0);
        run(enc(1, 2, 7, 0, 6'h2B), 0, 0, 0);
        chk("t4_slt", rf[6], 32'd1);
        chk("t4_sltu", rf[7], 32'd0);
        rf[1] = 32'd1; rf[2] = 32'h80000000;
        run(enc(1, 2, 8, 0, 6'h07), 0, 0, 0);
        chk("t4_srav", rf[8], 32'hC0000000);

        run(32'h8C220000, 0, 0, 0);
        run(enc(1, 2, 3, 0, 6'h3F), 0, 0, 0);

        rf[1] = 32'd5; rf[2] = 32'd7; rf[3] = 32'h55;
        inst_valid = 1'b1;
        inst = enc(1, 2, 3, 0, 6'h21);
        @(posedge CLK); #1 inst_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        chk("mid_we", {31'd0, WE}, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        chk("mid_ovf", {31'd0, ovf}, 32'd0);
        chk("mid_zero", {31'd0, zero}, 32'd0);
        chk("mid_ill", {31'd0, illegal}, 32'd0);
        chk("mid_waddr", {27'd0, W_Addr}, 32'd0);
        chk("mid_wdata", W_Data, 32'd0);
        chk("mid_ready", {31'd0, inst_ready}, 32'd1);
        chk("mid_state", 32'(dut.state), 32'(IDLE));
        @(posedge CLK); #1 chk("mid_we2", {31'd0, WE}, 32'd0);
        @(posedge CLK); #1 chk("mid_r3", rf[3], 32'h55);
        @(negedge CLK) RST = 1'b0;
        run(enc(1, 2, 3, 0, 6'h21), 0, 0, 0);
        chk("t6_r3", rf[3], 32'd12);

        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        rf[1] = 32'h7FFFFFFF; rf[2] = 32'h80000000; rf[3] = 32'd0;
        for (int k = 0; k < 60; k++) begin
            ri = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)), 5'($urandom), lf[$urandom_range(0, 15)]};
            if ($urandom_range(0, 7) == 0) ri[31:26] = 6'($urandom_range(1, 63));
            if ($urandom_range(0, 9) == 0) ri[5:0] = 6'h01;
            run(ri, 0, 0, 0);
            if (k % 10 == 9) for (int j = 1; j < 8; j++) rf[j] = $urandom;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
